// File: rtl/dsp_macro.sv
// dsp_macro: pipelined multiply-accumulate slice, P = A*B + C + CARRYIN.
// Three register stages (inputs, product, result); latency 3, one result per cycle.
// There is no handshake: every input is sampled on every rising CLK edge,
// and P is always the registered result of the inputs sampled two edges earlier.
// Optional pre-adder: define DSP_MACRO_PREADD_D_EN to add port D and compute
// P = (A+D)*B + C + CARRYIN.
module dsp_macro #(
    parameter int A_WIDTH     = 8,
    parameter int B_WIDTH     = 8,
    parameter int C_WIDTH     = 16,
    parameter int P_WIDTH     = 16,
    parameter int SIGNED_MODE = 1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               CARRYIN,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [C_WIDTH-1:0] C,
`ifdef DSP_MACRO_PREADD_D_EN
    input  logic [A_WIDTH-1:0] D,
`endif
    output logic [P_WIDTH-1:0] P
);

`ifdef DSP_MACRO_PREADD_D_EN
    localparam int AW = A_WIDTH + 1;   // pre-adder output is one bit wider than A
`else
    localparam int AW = A_WIDTH;
`endif
    localparam int MW = AW + B_WIDTH;                      // full product width
    localparam int SW = (MW > P_WIDTH) ? MW : P_WIDTH;     // post-add working width

    localparam logic IS_SIGNED = (SIGNED_MODE != 0);

    // stage 1 registers
    logic [A_WIDTH-1:0] a1;
    logic [B_WIDTH-1:0] b1;
    logic [C_WIDTH-1:0] c1;
    logic               ci1;
`ifdef DSP_MACRO_PREADD_D_EN
    logic [A_WIDTH-1:0] d1;
`endif

    // stage 2 registers
    logic [MW-1:0]      m;
    logic [C_WIDTH-1:0] c2;
    logic               ci2;

    // combinational multiply / post-add
    logic [AW-1:0] a_op;
    logic [MW-1:0] a_ext;
    logic [MW-1:0] b_ext;
    logic [MW-1:0] prod;
    logic [SW-1:0] m_ext;
    logic [SW-1:0] c_ext;
    logic [SW-1:0] sum;

    // Stage 1: capture all operands every cycle
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a1  <= '0;
            b1  <= '0;
            c1  <= '0;
            ci1 <= 1'b0;
`ifdef DSP_MACRO_PREADD_D_EN
            d1  <= '0;
`endif
        end else begin
            a1  <= A;
            b1  <= B;
            c1  <= C;
            ci1 <= CARRYIN;
`ifdef DSP_MACRO_PREADD_D_EN
            d1  <= D;
`endif
        end
    end

`ifdef DSP_MACRO_PREADD_D_EN
    // Pre-adder: extend both operands by one bit so A1+D1 can never overflow
    always_comb begin
        a_op = {IS_SIGNED & a1[A_WIDTH-1], a1} + {IS_SIGNED & d1[A_WIDTH-1], d1};
    end
`else
    // Without the pre-adder the multiplicand is the stage-1 A register
    always_comb begin
        a_op = a1;
    end
`endif

    // Multiplier: extend both factors to the product width, so the low MW
    // bits of an unsigned multiply equal the signed or unsigned product
    always_comb begin
        a_ext = {{(MW-AW){IS_SIGNED & a_op[AW-1]}}, a_op};
        b_ext = {{(MW-B_WIDTH){IS_SIGNED & b1[B_WIDTH-1]}}, b1};
        prod  = a_ext * b_ext;
    end

    // Stage 2: product register, with C and carry-in delayed to match
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            m   <= '0;
            c2  <= '0;
            ci2 <= 1'b0;
        end else begin
            m   <= prod;
            c2  <= c1;
            ci2 <= ci1;
        end
    end

    // Post-adder: extend M and C to the working width, add carry-in as +0/+1
    always_comb begin
        m_ext = SW'(m);
        for (int i = MW; i < SW; i++) begin
            m_ext[i] = IS_SIGNED & m[MW-1];
        end
        c_ext = SW'(c2);
        for (int i = C_WIDTH; i < SW; i++) begin
            c_ext[i] = IS_SIGNED & c2[C_WIDTH-1];
        end
        sum = m_ext + c_ext + {{(SW-1){1'b0}}, ci2};
    end

    // Stage 3: result register, wraps modulo 2^P_WIDTH
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            P <= '0;
        end else begin
            P <= sum[P_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_dsp_macro.sv
// tb_dsp_macro: directed and random checks of dsp_macro at its default
// parameters (8x8 signed, 16-bit C and P). Compile with DSP_MACRO_PREADD_D_EN
// defined to also cover the pre-adder.
module tb_dsp_macro;

    logic        clk;
    logic        rstn;
    logic        carryin;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic [7:0]  d;
    logic [15:0] p;

    logic [15:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    dsp_macro dut (
        .CLK     (clk),
        .RSTN    (rstn),
        .CARRYIN (carryin),
        .A       (a),
        .B       (b),
        .C       (c),
`ifdef DSP_MACRO_PREADD_D_EN
        .D       (d),
`endif
        .P       (p)
    );

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: signed integer arithmetic truncated to 16 bits
    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv,
                                          input logic [15:0] cv, input logic civ,
                                          input logic [7:0] dv);
        int x;
        int y;
        int z;
        int k;
        int r;
        x = $signed(av);
`ifdef DSP_MACRO_PREADD_D_EN
        x = x + int'($signed(dv));
`else
        k = int'(dv);   // D has no effect without the pre-adder
        x = x + (k & 0);
`endif
        y = $signed(bv);
        z = $signed(cv);
        k = civ ? 1 : 0;
        r = x * y + z + k;
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Driver: apply one cycle of inputs, clock it in, then pop and compare.
    // use_fixed selects a hand-computed expected value instead of the model.
    task automatic step(input logic rv, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] cv, input logic civ, input logic [7:0] dv,
                        input logic use_fixed, input logic [15:0] fixed_v,
                        input string tag);
        logic [15:0] e;
        @(negedge clk);
        rstn    = rv;
        a       = av;
        b       = bv;
        c       = cv;
        carryin = civ;
        d       = dv;
        @(posedge clk);
        #1;
        if (!rv) begin
            // reset flushes everything in flight; next two results are zero
            exp_q.delete();
            exp_q.push_back(16'h0000);
            exp_q.push_back(16'h0000);
            check({tag, "_rst"}, p, 16'h0000);
        end else begin
            exp_q.push_back(use_fixed ? fixed_v : model(av, bv, cv, civ, dv));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s observed=empty_queue expected=entry", tag);
            end else begin
                e = exp_q.pop_front();
                check(tag, p, e);
            end
        end
    endtask

    task automatic idle(input string tag);
        step(1'b1, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0000, tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rstn    = 1'b0;
        a       = '0;
        b       = '0;
        c       = '0;
        d       = '0;
        carryin = 1'b0;

        // reset held 5 cycles with busy inputs: P stays 0
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'hA5, 8'h5A, 16'h1234, 1'b1, 8'h11, 1'b0, 16'h0, "reset_hold");
        end

        // first post-reset sample: 3*5+10+1 = 26, visible 3 cycles later, then 0
        step(1'b1, 8'd3, 8'd5, 16'd10, 1'b1, 8'h00, 1'b1, 16'h001A, "latency_first");
        for (int i = 0; i < 4; i++) idle("latency_tail");

        // signed extremes and wrap
        step(1'b1, 8'h80, 8'h80, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h4000, "neg128_sq");
        step(1'b1, 8'hFF, 8'h01, 16'h0000, 1'b0, 8'h00, 1'b1, 16'hFFFF, "neg1_x1");
        step(1'b1, 8'hFF, 8'h01, 16'h0001, 1'b0, 8'h00, 1'b1, 16'h0000, "neg1_plus1");
        step(1'b1, 8'h7F, 8'h7F, 16'h7FFF, 1'b1, 8'h00, 1'b1, 16'hBF01, "wrap");
        step(1'b1, 8'h7F, 8'h7F, 16'h7FFF, 1'b0, 8'h00, 1'b1, 16'hBF00, "wrap_noci");
        step(1'b1, 8'h80, 8'h7F, 16'h8000, 1'b1, 8'h00, 1'b1, 16'h4081, "neg_c");
`ifdef DSP_MACRO_PREADD_D_EN
        step(1'b1, 8'd2, 8'd4, 16'd1, 1'b0, 8'd3, 1'b1, 16'd21, "preadd_small");
        step(1'b1, 8'h7F, 8'h02, 16'h0000, 1'b0, 8'h7F, 1'b1, 16'h01FC, "preadd_wide");
        step(1'b1, 8'h80, 8'h02, 16'h0000, 1'b0, 8'h80, 1'b1, 16'hFE00, "preadd_neg");
`endif
        for (int i = 0; i < 3; i++) idle("directed_drain");

        // 500 back-to-back random vectors with a one-cycle reset in the middle
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                step(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 1'b0, 16'h0, "stream_mid_reset");
            end else begin
                step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 1'b0, 16'h0, "stream");
            end
        end
        for (int i = 0; i < 3; i++) idle("stream_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
